// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the burst write arbiter.
// master = arbiter view, slave = producers plus FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      fifo_full;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_din;
  logic [2:0]                active_id;
  logic [7:0]                beat_cnt;
  logic                      burst_done;

  modport master (
    input  req, req_data, req_last, fifo_full,
    output gnt, fifo_wr_en, fifo_din, active_id, beat_cnt, burst_done
  );

  modport slave (
    output req, req_data, req_last, fifo_full,
    input  gnt, fifo_wr_en, fifo_din, active_id, beat_cnt, burst_done
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Grant held until last beat, MAX_BURST beats, or request withdrawal; no buffering.
module fifo_wr_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              i_gnt,
  input  logic              i_req,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_req,
  output logic              o_last,
  output logic [DATA_W-1:0] o_data
);
  // Grant-masked lane terms; the top ORs them into the active-producer view.
  assign o_req  = i_gnt & i_req;
  assign o_last = i_gnt & i_last;
  assign o_data = i_gnt ? i_data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);
  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [7:0]         LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

  state_t                         r_state, w_state_nxt;
  logic [NUM_REQ-1:0]             r_gnt, w_gnt_nxt;
  logic [2:0]                     r_active_id, w_id_nxt;
  logic [2:0]                     r_last_id, w_last_nxt;
  logic [7:0]                     r_beat_cnt, w_cnt_nxt;

  logic [NUM_REQ-1:0]             w_lane_req, w_lane_last;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_lane_data;
  logic                           w_act_req, w_act_last, w_beat, w_done;
  logic [DATA_W-1:0]              w_act_data;

  logic                           w_found_hi, w_found_lo;
  logic [2:0]                     w_pick_hi, w_pick_lo, w_pick;
  logic [NUM_REQ-1:0]             w_pick_oh;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .i_gnt  (r_gnt[g]),
      .i_req  (bus.req[g]),
      .i_last (bus.req_last[g]),
      .i_data (bus.req_data[g*DATA_W +: DATA_W]),
      .o_req  (w_lane_req[g]),
      .o_last (w_lane_last[g]),
      .o_data (w_lane_data[g])
    );
  end

  always_comb begin
    w_act_data = '0;
    for (int i = 0; i < NUM_REQ; i++) w_act_data |= w_lane_data[i];
  end

  assign w_act_req  = |w_lane_req;
  assign w_act_last = |w_lane_last;
  assign w_beat     = (r_state == BURST) && w_act_req && !bus.fifo_full;

  // Round robin: lowest requester above last_id wins, else lowest overall (wrap).
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_found_lo = 1'b1;
        w_pick_lo  = 3'(i);
      end
      if (bus.req[i] && (i > int'(r_last_id))) begin
        w_found_hi = 1'b1;
        w_pick_hi  = 3'(i);
      end
    end
    w_pick    = w_found_hi ? w_pick_hi : w_pick_lo;
    w_pick_oh = ONE << w_pick;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_active_id <= '0;
      r_last_id   <= 3'(NUM_REQ - 1);
      r_beat_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_active_id <= w_id_nxt;
      r_last_id   <= w_last_nxt;
      r_beat_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_active_id;
    w_last_nxt  = r_last_id;
    w_cnt_nxt   = r_beat_cnt;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found_lo) begin
          w_state_nxt = BURST;
          w_gnt_nxt   = w_pick_oh;
          w_id_nxt    = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (!w_act_req) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_active_id;
        end else if (w_beat) begin
          w_cnt_nxt = r_beat_cnt + 8'd1;
          // req_last only counts on a real beat, so a full FIFO defers it.
          if (w_act_last || (r_beat_cnt == LAST_BEAT)) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_last_nxt  = r_active_id;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.fifo_wr_en = w_beat;
  assign bus.fifo_din   = w_beat ? w_act_data : '0;
  assign bus.gnt        = r_gnt;
  assign bus.active_id  = r_active_id;
  assign bus.beat_cnt   = r_beat_cnt;
  assign bus.burst_done = w_done;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_gnt));
  a_wr_legal:   assert property (@(posedge clk) disable iff (!rst)
                  bus.fifo_wr_en |-> (!bus.fifo_full && (r_gnt != '0)));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios from queued producer beats plus
// a random run compared against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4, DW = 8, MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();
  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0, n_fail = 0;

  logic [DW-1:0]  qd [NR][$];
  logic           ql [NR][$];
  logic [NR-1:0]  wrote = '0;
  bit             mon_on = 1'b0;
  logic [NR-1:0]  log_gnt [$];
  logic           log_wr [$];
  logic [DW-1:0]  log_din [$];
  logic           log_done [$];
  logic [7:0]     log_cnt [$];

  always @(negedge clk) begin
    wrote <= bus.fifo_wr_en ? bus.gnt : '0;
    if (mon_on) begin
      log_gnt.push_back(bus.gnt);
      log_wr.push_back(bus.fifo_wr_en);
      log_din.push_back(bus.fifo_din);
      log_done.push_back(bus.burst_done);
      log_cnt.push_back(bus.beat_cnt);
    end
  end

  task automatic log_clear();
    log_gnt.delete(); log_wr.delete(); log_din.delete(); log_done.delete(); log_cnt.delete();
  endtask

  task automatic drive_q();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]                = (qd[i].size() != 0);
      bus.req_data[i*DW +: DW]  = (qd[i].size() != 0) ? qd[i][0] : '0;
      bus.req_last[i]           = (ql[i].size() != 0) ? ql[i][0] : 1'b0;
    end
  endtask

  // Each cycle: retire the beat written at the previous edge, present the next.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++)
        if (wrote[i] && qd[i].size() != 0) begin
          void'(qd[i].pop_front());
          void'(ql[i].pop_front());
        end
      drive_q();
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b0;
    for (int i = 0; i < NR; i++) begin qd[i].delete(); ql[i].delete(); end
    bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    log_clear();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    bus.req = '1; bus.req_data = '1; bus.req_last = '0; bus.fifo_full = 1'b0;
    #12;
    n_checks++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %0h want 0", bus.gnt); end
    n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b want 0", bus.fifo_wr_en); end
    n_checks++; if (bus.fifo_din !== '0) begin n_fail++; $display("FAIL reset_din: got %0h want 0", bus.fifo_din); end
    n_checks++; if (bus.beat_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d want 0", bus.beat_cnt); end
    n_checks++; if (bus.burst_done !== 1'b0) begin n_fail++; $display("FAIL reset_burst_done: got %0b want 0", bus.burst_done); end
    n_checks++; if (bus.active_id !== 3'd0) begin n_fail++; $display("FAIL reset_active_id: got %0d want 0", bus.active_id); end
  endtask

  task automatic test_single_burst();
    int nw = 0;
    apply_reset();
    mon_on = 1'b1;
    qd[0].push_back(8'h11); ql[0].push_back(1'b0);
    qd[0].push_back(8'h22); ql[0].push_back(1'b1);
    drive_q();
    run(4);
    mon_on = 1'b0;
    foreach (log_wr[k]) if (log_wr[k]) nw++;
    n_checks++; if (log_gnt[0] !== 4'b0000) begin n_fail++; $display("FAIL sb_gnt_same_cycle: got %0h want 0", log_gnt[0]); end
    n_checks++; if (log_gnt[1] !== 4'b0001) begin n_fail++; $display("FAIL sb_gnt_next_cycle: got %0h want 1", log_gnt[1]); end
    n_checks++; if ({log_wr[1], log_din[1], log_done[1]} !== {1'b1, 8'h11, 1'b0}) begin
      n_fail++; $display("FAIL sb_beat1: got wr=%0b din=%0h done=%0b want 1/11/0", log_wr[1], log_din[1], log_done[1]); end
    n_checks++; if ({log_wr[2], log_din[2], log_done[2]} !== {1'b1, 8'h22, 1'b1}) begin
      n_fail++; $display("FAIL sb_beat2: got wr=%0b din=%0h done=%0b want 1/22/1", log_wr[2], log_din[2], log_done[2]); end
    n_checks++; if (log_gnt[3] !== 4'b0000) begin n_fail++; $display("FAIL sb_release: got %0h want 0", log_gnt[3]); end
    n_checks++; if (nw != 2) begin n_fail++; $display("FAIL sb_write_count: got %0d want 2", nw); end
  endtask

  task automatic test_round_robin();
    int gseq[$], wcnt[$], gaps[$], wdat[$];
    int idle = 0;
    logic [NR-1:0] prev = '0;
    apply_reset();
    mon_on = 1'b1;
    for (int i = 0; i < NR; i++)
      for (int b = 0; b < 20; b++) begin qd[i].push_back(8'((i << 4) | (b & 15))); ql[i].push_back(1'b0); end
    drive_q();
    run(27);
    mon_on = 1'b0;
    foreach (log_gnt[k]) begin
      if (log_gnt[k] != '0 && prev == '0) begin
        gseq.push_back(int'(log_gnt[k]));
        wcnt.push_back(0);
        if (gseq.size() > 1) gaps.push_back(idle);
      end
      if (log_gnt[k] == '0) idle++; else idle = 0;
      if (log_wr[k] && wcnt.size() != 0) wcnt[wcnt.size()-1]++;
      if (log_wr[k]) wdat.push_back(int'(log_din[k]));
      prev = log_gnt[k];
    end
    n_checks++; if (gseq.size() < 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d want >=5", gseq.size()); end
    for (int k = 0; k < 5 && k < gseq.size(); k++) begin
      n_checks++; if (gseq[k] != (1 << (k % NR))) begin n_fail++; $display("FAIL rr_order[%0d]: got %0h want %0h", k, gseq[k], 1 << (k % NR)); end
    end
    for (int k = 0; k < 4 && k < wcnt.size(); k++) begin
      n_checks++; if (wcnt[k] != MB) begin n_fail++; $display("FAIL rr_beats[%0d]: got %0d want %0d", k, wcnt[k], MB); end
    end
    for (int k = 0; k < 4 && k < gaps.size(); k++) begin
      n_checks++; if (gaps[k] != 1) begin n_fail++; $display("FAIL rr_idle_gap[%0d]: got %0d want 1", k, gaps[k]); end
    end
    n_checks++; if (wdat.size() < 16) begin n_fail++; $display("FAIL rr_write_total: got %0d want >=16", wdat.size()); end
    for (int j = 0; j < 16 && j < wdat.size(); j++) begin
      n_checks++; if (wdat[j] != (((j / 4) << 4) | (j % 4))) begin
        n_fail++; $display("FAIL rr_data[%0d]: got %0h want %0h", j, wdat[j], ((j / 4) << 4) | (j % 4)); end
    end
  endtask

  task automatic test_fifo_full_stall();
    int wdat[$];
    apply_reset();
    mon_on = 1'b1;
    for (int b = 0; b < 4; b++) begin qd[2].push_back(8'(8'h20 + b)); ql[2].push_back(1'b0); end
    drive_q();
    run(1);
    run(1);
    bus.fifo_full = 1'b1;
    run(3);
    bus.fifo_full = 1'b0;
    run(5);
    mon_on = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      n_checks++; if ({log_wr[k], log_cnt[k], log_gnt[k]} !== {1'b0, 8'd1, 4'b0100}) begin
        n_fail++; $display("FAIL stall[%0d]: got wr=%0b cnt=%0d gnt=%0h want 0/1/4", k, log_wr[k], log_cnt[k], log_gnt[k]); end
    end
    foreach (log_wr[k]) if (log_wr[k]) wdat.push_back(int'(log_din[k]));
    n_checks++; if (wdat.size() != 4) begin n_fail++; $display("FAIL stall_write_count: got %0d want 4", wdat.size()); end
    for (int j = 0; j < 4 && j < wdat.size(); j++) begin
      n_checks++; if (wdat[j] != 8'h20 + j) begin n_fail++; $display("FAIL stall_data[%0d]: got %0h want %0h", j, wdat[j], 8'h20 + j); end
    end
    n_checks++; if ({log_wr[7], log_done[7]} !== 2'b11) begin n_fail++; $display("FAIL stall_final: got wr=%0b done=%0b want 1/1", log_wr[7], log_done[7]); end
    n_checks++; if (log_gnt[8] !== 4'b0000) begin n_fail++; $display("FAIL stall_release: got %0h want 0", log_gnt[8]); end
  endtask

  task automatic test_req_drop();
    apply_reset();
    mon_on = 1'b1;
    qd[1].push_back(8'h31); ql[1].push_back(1'b0);
    for (int b = 0; b < 8; b++) begin qd[3].push_back(8'(8'h40 + b)); ql[3].push_back(1'b0); end
    drive_q();
    run(5);
    mon_on = 1'b0;
    n_checks++; if ({log_gnt[1], log_wr[1], log_din[1]} !== {4'b0010, 1'b1, 8'h31}) begin
      n_fail++; $display("FAIL drop_beat: got gnt=%0h wr=%0b din=%0h want 2/1/31", log_gnt[1], log_wr[1], log_din[1]); end
    n_checks++; if ({log_wr[2], log_done[2]} !== 2'b01) begin
      n_fail++; $display("FAIL drop_release: got wr=%0b done=%0b want 0/1", log_wr[2], log_done[2]); end
    n_checks++; if (log_gnt[3] !== 4'b0000) begin n_fail++; $display("FAIL drop_idle: got %0h want 0", log_gnt[3]); end
    n_checks++; if (log_gnt[4] !== 4'b1000) begin n_fail++; $display("FAIL drop_next_grant: got %0h want 8", log_gnt[4]); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int b = 0; b < 8; b++) begin qd[1].push_back(8'(8'h50 + b)); ql[1].push_back(1'b0); end
    drive_q();
    run(3);
    n_checks++; if ({bus.gnt, bus.beat_cnt} !== {4'b0010, 8'd2}) begin
      n_fail++; $display("FAIL mr_before: got gnt=%0h cnt=%0d want 2/2", bus.gnt, bus.beat_cnt); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({bus.gnt, bus.fifo_wr_en, bus.beat_cnt} !== {4'b0000, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL mr_async: got gnt=%0h wr=%0b cnt=%0d want 0/0/0", bus.gnt, bus.fifo_wr_en, bus.beat_cnt); end
    for (int i = 0; i < NR; i++) begin qd[i].delete(); ql[i].delete(); end
    for (int b = 0; b < 4; b++) begin
      qd[2].push_back(8'(8'h60 + b)); ql[2].push_back(1'b0);
      qd[3].push_back(8'(8'h70 + b)); ql[3].push_back(1'b0);
    end
    drive_q();
    @(posedge clk); #1 rst = 1'b1;
    log_clear();
    mon_on = 1'b1;
    run(2);
    mon_on = 1'b0;
    n_checks++; if (log_gnt[1] !== 4'b0100) begin n_fail++; $display("FAIL mr_restart: got %0h want 4", log_gnt[1]); end
  endtask

  task automatic test_single_beat();
    apply_reset();
    mon_on = 1'b1;
    for (int b = 0; b < 6; b++) begin qd[0].push_back(8'(8'h60 + b)); ql[0].push_back(1'b1); end
    drive_q();
    run(12);
    mon_on = 1'b0;
    for (int k = 0; k < 12; k++) begin
      n_checks++; if ({log_gnt[k], log_wr[k]} !== {((k % 2) == 1) ? 4'b0001 : 4'b0000, (k % 2) == 1}) begin
        n_fail++; $display("FAIL sbeat[%0d]: got gnt=%0h wr=%0b", k, log_gnt[k], log_wr[k]); end
      if (k % 2 == 1) begin
        n_checks++; if (log_din[k] !== 8'(8'h60 + k / 2)) begin
          n_fail++; $display("FAIL sbeat_data[%0d]: got %0h want %0h", k, log_din[k], 8'h60 + k / 2); end
      end
    end
  endtask

  task automatic test_random();
    int own = -1, cnt = 0, lst = NR - 1;
    logic [NR-1:0] e_gnt;
    logic act, beat, e_done, fin;
    logic [DW-1:0] e_din;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (wrote[i] || !bus.req[i]) begin
          bus.req[i]               = ($urandom_range(0, 9) < 6);
          bus.req_data[i*DW +: DW] = DW'($urandom);
          bus.req_last[i]          = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 9) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      e_gnt = '0; act = 1'b0; fin = 1'b0;
      if (own >= 0) begin
        e_gnt[own] = 1'b1;
        act = bus.req[own];
        fin = bus.req_last[own] || (cnt == MB - 1);
      end
      beat   = act && !bus.fifo_full;
      e_din  = beat ? bus.req_data[own*DW +: DW] : '0;
      e_done = (own >= 0) && (!act || (beat && fin));
      n_checks++; if (bus.gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt c=%0d: got %0h want %0h", c, bus.gnt, e_gnt); end
      n_checks++; if (bus.fifo_wr_en !== beat) begin n_fail++; $display("FAIL rnd_wr c=%0d: got %0b want %0b", c, bus.fifo_wr_en, beat); end
      n_checks++; if (bus.fifo_din !== e_din) begin n_fail++; $display("FAIL rnd_din c=%0d: got %0h want %0h", c, bus.fifo_din, e_din); end
      n_checks++; if (bus.burst_done !== e_done) begin n_fail++; $display("FAIL rnd_done c=%0d: got %0b want %0b", c, bus.burst_done, e_done); end
      n_checks++; if (bus.beat_cnt !== 8'(cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, bus.beat_cnt, cnt); end
      if (own >= 0) begin
        n_checks++; if (bus.active_id !== 3'(own)) begin n_fail++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, bus.active_id, own); end
      end
      n_checks++; if (bus.fifo_wr_en && (bus.fifo_full || bus.gnt == '0)) begin
        n_fail++; $display("FAIL rnd_illegal_wr c=%0d: got full=%0b gnt=%0h", c, bus.fifo_full, bus.gnt); end
      // Advance the arbitration model by one clock.
      if (own < 0) begin
        for (int k = 1; k <= NR; k++)
          if (own < 0 && bus.req[(lst + k) % NR]) begin own = (lst + k) % NR; cnt = 0; end
      end else if (!act) begin
        lst = own; own = -1;
      end else if (beat) begin
        cnt++;
        if (fin) begin lst = own; own = -1; end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_fifo_full_stall();
    test_req_drop();
    test_mid_reset();
    test_single_beat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
